// File: rtl/logic_clk_div_pkg.sv
// Shared types for the logic clock divider sequencer: FSM states, configuration record, limits.
// Optional LOGIC_CLK_DIV_DUTY_EN adds a separate low-phase length to the configuration record.
package logic_clk_div_pkg;

   // Field widths of the configuration record; the sequencer's COUNTER_BITS/BURST_BITS must not exceed them.
   localparam int unsigned CFG_CNT_W       = 32;
   localparam int unsigned CFG_BURST_W     = 16;
   localparam int unsigned HALF_PERIOD_MIN = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_LO = 2'd1,
      RUN_HI = 2'd2
   } state_e;

   typedef struct packed {
      logic [CFG_CNT_W-1:0]   half_period;
      logic [CFG_BURST_W-1:0] burst_len;
`ifdef LOGIC_CLK_DIV_DUTY_EN
      logic [CFG_CNT_W-1:0]   low_period;
`endif
   } cfg_t;

`ifdef LOGIC_CLK_DIV_DUTY_EN
   localparam cfg_t CFG_RESET = '{half_period: CFG_CNT_W'(HALF_PERIOD_MIN),
                                  burst_len:   '0,
                                  low_period:  CFG_CNT_W'(HALF_PERIOD_MIN)};
`else
   localparam cfg_t CFG_RESET = '{half_period: CFG_CNT_W'(HALF_PERIOD_MIN),
                                  burst_len:   '0};
`endif

   // A zero phase length would never reach terminal count, so it is promoted to the minimum.
   function automatic logic [CFG_CNT_W-1:0] clamp_period(input logic [CFG_CNT_W-1:0] p);
      return (p == '0) ? CFG_CNT_W'(HALF_PERIOD_MIN) : p;
   endfunction

endpackage

// File: rtl/logic_clk_div_phase_cnt.sv
// Phase counter for the clock divider: counts up from zero until cleared, flags when it equals limit_i.
module logic_clk_div_phase_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic [W-1:0] limit_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clear_i ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/logic_clk_div_seq.sv
// Sequencer for the logic clock divider: start/stop/burst control, glitch-free ratio changes via a shadow register.
// Define LOGIC_CLK_DIV_DUTY_EN to add cfg_low_period for an independent low-phase length.
module logic_clk_div_seq
   import logic_clk_div_pkg::*;
#(
   parameter int COUNTER_BITS = 32,
   parameter int BURST_BITS   = 16
) (
   input  logic                    master_clk,
   input  logic                    rst,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [COUNTER_BITS-1:0] cfg_half_period,
`ifdef LOGIC_CLK_DIV_DUTY_EN
   input  logic [COUNTER_BITS-1:0] cfg_low_period,
`endif
   input  logic [BURST_BITS-1:0]   cfg_burst_len,
   input  logic                    start,
   input  logic                    stop,
   output logic                    output_clk,
   output logic                    busy,
   output logic                    done,
   output logic [BURST_BITS-1:0]   edge_count
);

   state_e                  state_q, state_d;
   cfg_t                    active_q, active_d, pend_q, pend_d, cfg_in;
   logic                    pend_full_q, pend_full_d;
   logic                    stop_req_q, stop_req_d;
   logic                    clk_q, clk_d, done_q, done_d, busy_q, busy_d, rdy_q, rdy_d;
   logic [BURST_BITS-1:0]   edge_q, edge_d;
   logic [COUNTER_BITS-1:0] hi_limit, lo_limit, limit;
   logic                    cnt_clear, tc, cfg_fire, boundary, burst_hit, leave_hi;

   function automatic logic [BURST_BITS-1:0] sat_inc(input logic [BURST_BITS-1:0] v);
      return (&v) ? v : v + BURST_BITS'(1);
   endfunction

   always_comb begin
      cfg_in             = CFG_RESET;
      cfg_in.half_period = clamp_period(CFG_CNT_W'(cfg_half_period));
      cfg_in.burst_len   = CFG_BURST_W'(cfg_burst_len);
`ifdef LOGIC_CLK_DIV_DUTY_EN
      cfg_in.low_period  = clamp_period(CFG_CNT_W'(cfg_low_period));
`endif
   end

   assign hi_limit = COUNTER_BITS'(active_q.half_period) - COUNTER_BITS'(1);
`ifdef LOGIC_CLK_DIV_DUTY_EN
   assign lo_limit = COUNTER_BITS'(active_q.low_period) - COUNTER_BITS'(1);
`else
   assign lo_limit = hi_limit;
`endif
   assign limit = (state_q == RUN_LO) ? lo_limit : hi_limit;

   logic_clk_div_phase_cnt #(
      .W(COUNTER_BITS)
   ) u_phase_cnt (
      .clk_i   (master_clk),
      .rst_i   (rst),
      .clear_i (cnt_clear),
      .limit_i (limit),
      .tc_o    (tc)
   );

   assign cfg_fire  = cfg_valid && rdy_q;
   assign burst_hit = (active_q.burst_len != '0) && (CFG_BURST_W'(edge_q) == active_q.burst_len);
   assign leave_hi  = stop_req_q || stop || burst_hit;
   // Config may only change where output_clk is low and a phase is starting afresh.
   assign boundary  = ((state_q == RUN_HI) && tc) || ((state_q == RUN_LO) && stop);

   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start && !stop) state_d = RUN_LO;
         RUN_LO:  if (stop) state_d = IDLE;
                  else if (tc) state_d = RUN_HI;
         RUN_HI:  if (tc) state_d = leave_hi ? IDLE : RUN_LO;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      clk_d      = clk_q;
      done_d     = 1'b0;
      edge_d     = edge_q;
      stop_req_d = stop_req_q;
      cnt_clear  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_clear  = 1'b1;
            clk_d      = 1'b0;
            stop_req_d = 1'b0;
            if (start && !stop) edge_d = '0;
         end
         RUN_LO: begin
            if (stop) begin
               cnt_clear = 1'b1;
               clk_d     = 1'b0;
            end else if (tc) begin
               cnt_clear = 1'b1;
               clk_d     = 1'b1;
               edge_d    = sat_inc(edge_q);
            end
         end
         RUN_HI: begin
            if (stop) stop_req_d = 1'b1;
            if (tc) begin
               cnt_clear = 1'b1;
               clk_d     = 1'b0;
               if (leave_hi) begin
                  stop_req_d = 1'b0;
                  done_d     = burst_hit;
               end
            end
         end
         default: begin
            cnt_clear  = 1'b1;
            clk_d      = 1'b0;
            stop_req_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
      rdy_d  = (state_d == IDLE) || !pend_full_d;
   end

   // A transfer at a phase boundary goes straight to the active set, so the shadow never lingers in IDLE.
   always_comb begin
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      if (cfg_fire) begin
         if ((state_q == IDLE) || boundary) begin
            active_d = cfg_in;
         end else begin
            pend_d      = cfg_in;
            pend_full_d = 1'b1;
         end
      end else if (boundary && pend_full_q) begin
         active_d    = pend_q;
         pend_full_d = 1'b0;
      end
   end

   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         active_q    <= CFG_RESET;
         pend_full_q <= 1'b0;
         stop_req_q  <= 1'b0;
         clk_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         rdy_q       <= 1'b1;
         edge_q      <= '0;
      end else begin
         active_q    <= active_d;
         pend_full_q <= pend_full_d;
         stop_req_q  <= stop_req_d;
         clk_q       <= clk_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         rdy_q       <= rdy_d;
         edge_q      <= edge_d;
      end
   end

   always_ff @(posedge master_clk) begin
      pend_q <= pend_d;
   end

   assign output_clk = clk_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_ready  = rdy_q;
   assign edge_count = edge_q;

endmodule

// File: tb/tb_logic_clk_div_seq.sv
// Self-checking bench for logic_clk_div_seq against a closed-form waveform model.
module tb_logic_clk_div_seq;

   localparam int CB = 32;
   localparam int BB = 16;

   logic          master_clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [CB-1:0] cfg_half_period = '0;
   logic [BB-1:0] cfg_burst_len = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          output_clk, busy, done;
   logic [BB-1:0] edge_count;

   int checks = 0;
   int errors = 0;

   always #5 master_clk = ~master_clk;

   logic_clk_div_seq #(.COUNTER_BITS(CB), .BURST_BITS(BB)) dut (
      .master_clk      (master_clk),
      .rst             (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_half_period (cfg_half_period),
`ifdef LOGIC_CLK_DIV_DUTY_EN
      .cfg_low_period  (cfg_half_period),
`endif
      .cfg_burst_len   (cfg_burst_len),
      .start           (start),
      .stop            (stop),
      .output_clk      (output_clk),
      .busy            (busy),
      .done            (done),
      .edge_count      (edge_count)
   );

   // Model: n = clock edges since the start command was driven; rise k at n = 2hk-h+1, fall at n = 2hk+1.
   function automatic int m_h(input int h);
      return (h == 0) ? 1 : h;
   endfunction
   function automatic int m_end(input int h, input int b);
      return 2 * h * b + 1;
   endfunction
   function automatic bit m_clk(input int n, input int h, input int b);
      if (b > 0 && n >= m_end(h, b)) return 1'b0;
      if (n < h + 1) return 1'b0;
      return ((n - h - 1) % (2 * h)) < h;
   endfunction
   function automatic int m_edges(input int n, input int h, input int b);
      int r;
      if (b > 0 && n >= m_end(h, b)) return b;
      r = (n < h + 1) ? 0 : (n - h - 1) / (2 * h) + 1;
      return (r > 65535) ? 65535 : r;
   endfunction
   function automatic bit m_busy(input int n, input int h, input int b);
      return (b == 0) || (n < m_end(h, b));
   endfunction
   function automatic bit m_done(input int n, input int h, input int b);
      return (b > 0) && (n == m_end(h, b));
   endfunction

   task automatic tick();
      @(posedge master_clk);
      #1;
   endtask

   task automatic set_cfg(input int h, input int b);
      cfg_valid       = 1'b1;
      cfg_half_period = CB'(h);
      cfg_burst_len   = BB'(b);
      tick();
      cfg_valid       = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop(output bit ok);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (output_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b want 0", output_clk); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (edge_count !== '0) begin errors++; $display("FAIL reset_edges: got %0d want 0", edge_count); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_free_run();
      bit ok;
      set_cfg(3, 0);
      kick();
      for (int n = 1; n <= 30; n++) begin
         checks++; if (output_clk !== m_clk(n, 3, 0)) begin errors++; $display("FAIL free_clk n=%0d: got %b want %b", n, output_clk, m_clk(n, 3, 0)); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL free_busy n=%0d: got %b want 1", n, busy); end
         checks++; if (edge_count !== BB'(m_edges(n, 3, 0))) begin errors++; $display("FAIL free_edges n=%0d: got %0d want %0d", n, edge_count, m_edges(n, 3, 0)); end
         tick();
      end
      do_stop(ok);
      checks++; if (!ok) begin errors++; $display("FAIL free_stop: busy still %b after bound, want 0", busy); end
   endtask

   task automatic test_bursts();
      int hs[$];
      int bs[$];
      int h, b, e;
      hs = '{2, 0};
      bs = '{4, 3};
      for (int i = 0; i < 6; i++) begin
         hs.push_back(int'($urandom_range(0, 6)));
         bs.push_back(int'($urandom_range(1, 5)));
      end
      foreach (hs[k]) begin
         set_cfg(hs[k], bs[k]);
         h = m_h(hs[k]);
         b = bs[k];
         e = m_end(h, b);
         kick();
         for (int n = 1; n <= e + 2; n++) begin
            checks++; if (output_clk !== m_clk(n, h, b)) begin errors++; $display("FAIL burst_clk h=%0d b=%0d n=%0d: got %b want %b", h, b, n, output_clk, m_clk(n, h, b)); end
            checks++; if (busy !== m_busy(n, h, b)) begin errors++; $display("FAIL burst_busy h=%0d b=%0d n=%0d: got %b want %b", h, b, n, busy, m_busy(n, h, b)); end
            checks++; if (done !== m_done(n, h, b)) begin errors++; $display("FAIL burst_done h=%0d b=%0d n=%0d: got %b want %b", h, b, n, done, m_done(n, h, b)); end
            checks++; if (edge_count !== BB'(m_edges(n, h, b))) begin errors++; $display("FAIL burst_edges h=%0d b=%0d n=%0d: got %0d want %0d", h, b, n, edge_count, m_edges(n, h, b)); end
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL burst_ready n=%0d: got %b want 1", n, cfg_ready); end
            tick();
         end
      end
   endtask

   task automatic test_shadow();
      bit ok;
      bit exp_clk;
      set_cfg(5, 0);
      kick();
      for (int n = 1; n < 7; n++) tick();
      checks++; if (output_clk !== 1'b1) begin errors++; $display("FAIL shadow_high: got %b want 1", output_clk); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL shadow_ready0: got %b want 1", cfg_ready); end
      cfg_valid = 1'b1;
      cfg_half_period = CB'(2);
      tick();
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL shadow_ready1: got %b want 0", cfg_ready); end
      cfg_half_period = CB'(3);
      tick();
      cfg_valid = 1'b0;
      for (int n = 9; n <= 30; n++) begin
         exp_clk = (n < 11) ? 1'b1 : (((n - 11) % 4) >= 2);
         checks++; if (output_clk !== exp_clk) begin errors++; $display("FAIL shadow_clk n=%0d: got %b want %b", n, output_clk, exp_clk); end
         checks++; if (cfg_ready !== (n >= 11)) begin errors++; $display("FAIL shadow_ready n=%0d: got %b want %b", n, cfg_ready, n >= 11); end
         tick();
      end
      do_stop(ok);
      checks++; if (!ok) begin errors++; $display("FAIL shadow_stop: busy still %b after bound, want 0", busy); end
   endtask

   task automatic test_stop();
      set_cfg(4, 0);
      kick();
      for (int n = 1; n < 6; n++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int n = 7; n <= 10; n++) begin
         checks++; if (output_clk !== (n < 9)) begin errors++; $display("FAIL stop_hi_clk n=%0d: got %b want %b", n, output_clk, n < 9); end
         checks++; if (busy !== (n < 9)) begin errors++; $display("FAIL stop_hi_busy n=%0d: got %b want %b", n, busy, n < 9); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_hi_done n=%0d: got %b want 0", n, done); end
         tick();
      end
      kick();
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_lo_busy_before: got %b want 1", busy); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_lo_busy: got %b want 0", busy); end
      checks++; if (output_clk !== 1'b0) begin errors++; $display("FAIL stop_lo_clk: got %b want 0", output_clk); end
   endtask

   task automatic test_start_stop_same();
      set_cfg(1, 0);
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy i=%0d: got %b want 0", i, busy); end
         checks++; if (output_clk !== 1'b0) begin errors++; $display("FAIL same_clk i=%0d: got %b want 0", i, output_clk); end
         tick();
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      set_cfg(4, 0);
      kick();
      for (int n = 1; n < 5; n++) tick();
      checks++; if (output_clk !== 1'b1) begin errors++; $display("FAIL ares_high: got %b want 1", output_clk); end
      cfg_valid = 1'b1;
      cfg_half_period = CB'(7);
      tick();
      cfg_valid = 1'b0;
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ares_pend: got %b want 0", cfg_ready); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (output_clk !== 1'b0) begin errors++; $display("FAIL ares_clk: got %b want 0", output_clk); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ares_busy: got %b want 0", busy); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ares_ready: got %b want 1", cfg_ready); end
      checks++; if (edge_count !== '0) begin errors++; $display("FAIL ares_edges: got %0d want 0", edge_count); end
      #1;
      rst = 1'b0;
      tick();
      kick();
      for (int n = 1; n <= 8; n++) begin
         checks++; if (output_clk !== m_clk(n, 1, 0)) begin errors++; $display("FAIL ares_default_clk n=%0d: got %b want %b", n, output_clk, m_clk(n, 1, 0)); end
         tick();
      end
      do_stop(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ares_stop: busy still %b after bound, want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_bursts();
      test_shadow();
      test_stop();
      test_start_stop_same();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/logic_clk_div_seq.md
Name: logic_clk_div_seq

Overview:
Sequencing controller for the logic clock divider: owns the divide counter and output_clk generation, and sequences start, stop and finite bursts.
- Divide-ratio changes are accepted through a valid/ready handshake, buffered in a one-entry shadow register, and applied only at a falling edge of output_clk, so output_clk never produces a runt pulse.
- Sits between the AXI register interface (configuration and command strobes) and the clock output pin.

Parameters:
COUNTER_BITS, 32, width of the half-period count.
BURST_BITS, 16, width of the burst length and edge counter.

Ports:
master_clk  in  1  the single clock for all logic; output_clk is derived from it.
rst  in  1  asynchronous, active-high reset.
cfg_valid  in  1  a new half-period (and burst length) is offered.
cfg_ready  out  1  the shadow register can accept a configuration.
cfg_half_period  in  COUNTER_BITS  master_clk cycles per output phase; 0 is treated as 1.
cfg_burst_len  in  BURST_BITS  number of rising edges per burst; 0 means free-running.
start  in  1  single-cycle start command.
stop  in  1  single-cycle stop command.
output_clk  out  1  divided clock output.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a burst completes.
edge_count  out  BURST_BITS  rising edges issued since the last start; saturates at all-ones.

Behaviour:
- Reset, asynchronous: state=IDLE, output_clk=0, cnt=0, active half-period=1, active burst=0, pending empty, cfg_ready=1, busy=0, done=0, edge_count=0. Reset mid-burst forces output_clk low immediately, without waiting for an edge.
- FSM states: IDLE, RUN_LO, RUN_HI.
- Half-period H = max(cfg_half_period, 1). Output period = 2H master_clk cycles; duty is 50%.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready.
  - In IDLE, the config is written directly to the active registers; cfg_ready stays 1.
  - In RUN_*, the config is written to the pending register; cfg_ready = !pending_full.
- IDLE:
  - start && !stop -> RUN_LO; cnt=0, edge_count=0, output_clk stays 0.
  - start && stop in the same cycle -> stay in IDLE.
- RUN_LO: cnt increments each cycle. At cnt==H-1: cnt=0, output_clk=1, edge_count+1, go to RUN_HI.
- RUN_HI: cnt increments each cycle. At cnt==H-1 (the falling edge): cnt=0, output_clk=0, then the first matching rule below applies:
  - stop_req set, or burst>0 and edge_count==burst -> IDLE; done=1 for one cycle only when the exit is caused by burst completion.
  - pending full -> active config := pending, pending cleared, go to RUN_LO.
  - otherwise -> RUN_LO.
- Pending config applied on the falling edge that ends a burst: it is loaded into the active registers even though the FSM goes to IDLE.
- stop:
  - In RUN_LO, go to IDLE on the next cycle. output_clk is already low, so no glitch results.
  - In RUN_HI, set stop_req and exit at the next falling edge. stop_req clears on entering IDLE.
- start while in RUN_*: ignored.
- Timing: latency from the start cycle to the first output_clk rise is H+1 master_clk cycles. All outputs are registered.
- Counter: the compare uses the full COUNTER_BITS width. H = 2^COUNTER_BITS-1 is legal. The counter wraps only through the explicit clear.

Optional Feature:
LOGIC_CLK_DIV_DUTY_EN.
- Defined: adds input port cfg_low_period [COUNTER_BITS], with 0 treated as 1. It is shadowed and applied together with cfg_half_period. RUN_LO uses the low count and RUN_HI uses cfg_half_period as the high count. Period = high + low.
- Undefined: the port is absent and both phases use cfg_half_period.

Decomposition:
- Package logic_clk_div_pkg:
  - state enum (IDLE, RUN_LO, RUN_HI);
  - cfg struct {half_period, burst_len[, low_period]};
  - constant HALF_PERIOD_MIN=1.
- Sub-module logic_clk_div_phase_cnt: loadable counter with a terminal-count flag (inputs: clear, limit; output: tc). Instantiated once.

Test Plan:
- Reset released, cfg H=3, burst=0, then start -> output_clk first rises 4 cycles after start; period is 6 cycles; busy=1; edge_count increments once per rise.
- H=2, burst=4, start -> exactly 4 rising edges; done pulses one cycle at the 4th falling edge; IDLE; output_clk=0.
- Free-running H=5: push cfg H=2 while output is high, then push a second cfg -> the second push sees cfg_ready=0. The new period (4 cycles) starts exactly at the next falling edge; no high phase is shorter than 5 or 2 cycles.
- stop asserted mid-high phase with H=4 -> the high phase completes its full 4 cycles, then IDLE. stop asserted in the low phase -> IDLE on the next cycle.
- cfg_half_period=0 -> behaves as H=1 (output_clk period 2 cycles). start and stop in the same cycle from IDLE -> stays in IDLE, busy=0.
- rst pulsed asynchronously mid-high phase -> output_clk=0 and busy=0 without waiting for a clock edge; pending is cleared and cfg_ready=1.
